// File: rtl/block_scroll_generator_pkg.sv
// block_scroll_generator_pkg: shared widths, playfield geometry and shape codes
package block_scroll_generator_pkg;
  localparam int SHAPE_ENCODE_LENGTH = 3;
  localparam int COORDINATE_LENGTH = 11;
  localparam int SCREEN_WIDTH = 640;
  localparam int SLOT_SPACING = 256;
  localparam int NUM_SLOTS = 4;
  localparam int NUM_SHAPE_CODES = 6;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef enum logic [SHAPE_ENCODE_LENGTH-1:0] {
    SHAPE_SQUARE, SHAPE_BAR_H, SHAPE_BAR_V, SHAPE_L, SHAPE_T, SHAPE_Z
  } shape_e;
  // Folds the out-of-range top codes back onto the legal range
  function automatic int map_shape(int r, int n);
    return r < n ? r : r - n;
  endfunction
endpackage

// File: rtl/block_scroll_generator_lfsr.sv
// shape_lfsr: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with step enable
// and a shape code derived from the current state.
module shape_lfsr
  import block_scroll_generator_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED,
  parameter int SHAPE_W = SHAPE_ENCODE_LENGTH,
  parameter int NUM_SHAPES = NUM_SHAPE_CODES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_i,
  output logic [SHAPE_W-1:0] shape_o
);
  logic [15:0] q_q, q_d;
  always_comb q_d = step_i ? {q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5], q_q[15:1]} : q_q;
  always_ff @(posedge clk) q_q <= rst ? SEED : q_d;
  assign shape_o = SHAPE_W'(map_shape(int'(q_q[SHAPE_W-1:0]), NUM_SHAPES));
endmodule

// File: rtl/block_scroll_generator.sv
// block_scroll_generator: four scrolling obstacle slots with LFSR respawn shapes,
// a retire pulse and a saturating passed-block counter.
module block_scroll_generator
  import block_scroll_generator_pkg::*;
#(
  parameter int SHAPE_W = SHAPE_ENCODE_LENGTH,
  parameter int COORD_W = COORDINATE_LENGTH,
  parameter int NUM_SHAPES = NUM_SHAPE_CODES,
  parameter int SCREEN_W = SCREEN_WIDTH,
  parameter int SPACING = SLOT_SPACING,
  parameter logic [15:0] SEED = LFSR_SEED,
  parameter int CNT_W = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FRAME_TICK,
  input  logic                       RUN,
  input  logic [3:0]                 SPEED,
  output logic [NUM_SLOTS*SHAPE_W-1:0] BLOCK_SHAPE,
  output logic [NUM_SLOTS*COORD_W-1:0] BLOCK_START_X,
  output logic                       SCORE_PULSE,
  output logic [CNT_W-1:0]           PASSED_COUNT
);
  localparam int N = NUM_SLOTS;
  if (SCREEN_W + 3 * SPACING >= 2 ** COORD_W) begin : g_chk_screen
    $error("initial slot positions do not fit COORD_W");
  end
  if (N * SPACING + 15 >= 2 ** COORD_W) begin : g_chk_ring
    $error("respawn position does not fit COORD_W");
  end
  if (SPACING <= 15) begin : g_chk_spacing
    $error("SPACING must exceed the maximum SPEED");
  end
  if (N * SPACING < SCREEN_W) begin : g_chk_period
    $error("ring period shorter than the screen");
  end
  if (NUM_SHAPES <= 2 ** (SHAPE_W - 1) || NUM_SHAPES > 2 ** SHAPE_W) begin : g_chk_shapes
    $error("NUM_SHAPES out of range for SHAPE_W");
  end
  if (SEED == 16'h0) begin : g_chk_seed
    $error("SEED must be non-zero");
  end
  logic [COORD_W-1:0] x_q [N];
  logic [COORD_W-1:0] x_d [N];
  logic [SHAPE_W-1:0] shape_q [N];
  logic [SHAPE_W-1:0] shape_d [N];
  logic [SHAPE_W-1:0] new_shape;
  logic [N-1:0]       retire;
  logic               adv, pulse_q;
  logic [CNT_W-1:0]   cnt_q;
  assign adv = FRAME_TICK & RUN;
  shape_lfsr #(.SEED(SEED), .SHAPE_W(SHAPE_W), .NUM_SHAPES(NUM_SHAPES)) u_lfsr (
    .clk(CLK), .rst(RESET), .step_i(adv), .shape_o(new_shape)
  );
  // Retiring slots jump a full ring period ahead, so they never wrap through zero
  always_comb begin
    for (int k = 0; k < N; k++) begin
      retire[k] = adv && (x_q[k] < COORD_W'(SPEED));
      x_d[k] = retire[k] ? x_q[k] + COORD_W'(N * SPACING) - COORD_W'(SPEED)
             : adv ? x_q[k] - COORD_W'(SPEED) : x_q[k];
      shape_d[k] = retire[k] ? new_shape : shape_q[k];
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < N; k++) begin
        x_q[k] <= COORD_W'(SCREEN_W + k * SPACING);
        shape_q[k] <= '0;
      end
      pulse_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        x_q[k] <= x_d[k];
        shape_q[k] <= shape_d[k];
      end
      pulse_q <= |retire;
      cnt_q <= (|retire && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign BLOCK_SHAPE[(N-1-i)*SHAPE_W +: SHAPE_W] = shape_q[i];
    assign BLOCK_START_X[(N-1-i)*COORD_W +: COORD_W] = x_q[i];
  end
  assign SCORE_PULSE = pulse_q;
  assign PASSED_COUNT = cnt_q;
endmodule

// File: tb/tb_block_scroll_generator.sv
// tb_block_scroll_generator: directed checks of scrolling, retire, freeze,
// counter saturation (CNT_W=2 instance) and reset priority.
module tb_block_scroll_generator;
  logic        CLK, RESET, FRAME_TICK, RUN;
  logic [3:0]  SPEED;
  logic [11:0] shape1, shape2;
  logic [43:0] x1, x2;
  logic        pulse1, pulse2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;
  int total = 0, bad = 0;
  int mx[4];
  logic [2:0]  ms[4];
  logic [15:0] ml, lm;
  int mc, mc2, waited;
  logic mp;
  int exp_c2[5] = '{1, 2, 3, 3, 3};

  block_scroll_generator u_dut (
    .CLK(CLK), .RESET(RESET), .FRAME_TICK(FRAME_TICK), .RUN(RUN), .SPEED(SPEED),
    .BLOCK_SHAPE(shape1), .BLOCK_START_X(x1), .SCORE_PULSE(pulse1), .PASSED_COUNT(cnt1)
  );
  block_scroll_generator #(.CNT_W(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .FRAME_TICK(FRAME_TICK), .RUN(RUN), .SPEED(SPEED),
    .BLOCK_SHAPE(shape2), .BLOCK_START_X(x2), .SCORE_PULSE(pulse2), .PASSED_COUNT(cnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
  function automatic logic [2:0] map3(input logic [15:0] l);
    return (l[2:0] < 3'd6) ? l[2:0] : l[2:0] - 3'd6;
  endfunction
  function automatic logic [43:0] pack_x();
    logic [43:0] r;
    for (int k = 0; k < 4; k++) r[(3-k)*11 +: 11] = 11'(mx[k]);
    return r;
  endfunction
  function automatic logic [11:0] pack_s();
    logic [11:0] r;
    for (int k = 0; k < 4; k++) r[(3-k)*3 +: 3] = ms[k];
    return r;
  endfunction
  function automatic int obs_x(input int k);
    return int'(x1[(3-k)*11 +: 11]);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("x", {20'h0, x1}, {20'h0, pack_x()});
    check("x_dut2", {20'h0, x2}, {20'h0, pack_x()});
    check("shape", {52'h0, shape1}, {52'h0, pack_s()});
    check("pulse", {63'h0, pulse1}, {63'h0, mp});
    check("pulse_dut2", {63'h0, pulse2}, {63'h0, mp});
    check("count", {48'h0, cnt1}, 64'(mc));
    check("count_dut2", {62'h0, cnt2}, 64'(mc2));
    check("lfsr", {48'h0, u_dut.u_lfsr.q_q}, {48'h0, ml});
  endtask

  task automatic step(input logic ft, input logic rs);
    logic any;
    FRAME_TICK = ft;
    RESET = rs;
    @(posedge CLK);
    #1;
    FRAME_TICK = 1'b0;
    RESET = 1'b0;
    if (rs) begin
      for (int k = 0; k < 4; k++) begin
        mx[k] = 640 + k * 256;
        ms[k] = 3'd0;
      end
      ml = 16'hACE1;
      mc = 0;
      mc2 = 0;
      mp = 1'b0;
    end else if (ft && RUN) begin
      any = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (mx[k] < int'(SPEED)) begin
          mx[k] = mx[k] + 1024 - int'(SPEED);
          ms[k] = map3(ml);
          any = 1'b1;
        end else mx[k] = mx[k] - int'(SPEED);
      end
      mp = any;
      if (any && mc < 65535) mc++;
      if (any && mc2 < 3) mc2++;
      ml = lfsr_next(ml);
    end else mp = 1'b0;
    check_all();
  endtask

  initial begin
    RESET = 1'b1;
    FRAME_TICK = 1'b0;
    RUN = 1'b1;
    SPEED = 4'd4;
    step(0, 1);
    step(0, 1);
    check("reset_x", {20'h0, x1}, {20'h0, 11'd640, 11'd896, 11'd1152, 11'd1408});
    check("reset_shape", {52'h0, shape1}, 64'h0);
    check("reset_pulse", {63'h0, pulse1}, 64'h0);
    check("reset_count", {48'h0, cnt1}, 64'h0);
    step(1, 0);
    check("tick1_x", {20'h0, x1}, {20'h0, 11'd636, 11'd892, 11'd1148, 11'd1404});
    check("tick1_shape", {52'h0, shape1}, 64'h0);
    check("tick1_lfsr", {48'h0, u_dut.u_lfsr.q_q}, 64'h5670);
    for (int t = 2; t <= 160; t++) step(1, 0);
    check("t160_slot1_x", 64'(x1[43:33]), 64'd0);
    check("t160_pulse", {63'h0, pulse1}, 64'h0);
    lm = ml;
    step(1, 0);
    check("t161_slot1_x", 64'(x1[43:33]), 64'd1020);
    check("t161_slot2_x", 64'(x1[32:22]), 64'd252);
    check("t161_shape", 64'(shape1[11:9]), 64'(map3(lm)));
    check("t161_pulse", {63'h0, pulse1}, 64'h1);
    check("t161_count", {48'h0, cnt1}, 64'd1);
    check("sat_count_1", {62'h0, cnt2}, 64'(exp_c2[0]));
    step(0, 0);
    check("pulse_one_cycle", {63'h0, pulse1}, 64'h0);
    RUN = 1'b0;
    for (int t = 0; t < 10; t++) step(1, 0);
    check("freeze_x", 64'(x1[43:33]), 64'd1020);
    check("freeze_lfsr", {48'h0, u_dut.u_lfsr.q_q}, {48'h0, lfsr_next(lm)});
    RUN = 1'b1;
    SPEED = 4'd0;
    lm = ml;
    step(1, 0);
    check("speed0_x", 64'(x1[32:22]), 64'd252);
    check("speed0_lfsr", {48'h0, u_dut.u_lfsr.q_q}, {48'h0, lfsr_next(lm)});
    check("speed0_pulse", {63'h0, pulse1}, 64'h0);
    SPEED = 4'd4;
    for (int r = 1; r < 5; r++) begin
      waited = 0;
      do begin
        step(1, 0);
        waited++;
      end while (!pulse1 && waited < 400);
      check("retire_seen", {63'h0, pulse1}, 64'h1);
      check("sat_count", {62'h0, cnt2}, 64'(exp_c2[r]));
      check("full_count", {48'h0, cnt1}, 64'(r + 1));
    end
    waited = 0;
    while (!(mx[0] < 4 || mx[1] < 4 || mx[2] < 4 || mx[3] < 4) && waited < 400) begin
      step(1, 0);
      waited++;
    end
    check("retire_pending", 64'(waited < 400), 64'h1);
    step(1, 1);
    check("rst_retire_x", {20'h0, x1}, {20'h0, 11'd640, 11'd896, 11'd1152, 11'd1408});
    check("rst_retire_pulse", {63'h0, pulse1}, 64'h0);
    check("rst_retire_count", {48'h0, cnt1}, 64'h0);
    check("rst_retire_lfsr", {48'h0, u_dut.u_lfsr.q_q}, 64'hACE1);
    for (int t = 0; t < 10000; t++) begin
      SPEED = 4'($urandom_range(0, 15));
      step(1, 0);
      for (int k = 0; k < 4; k++)
        check("gap", 64'((obs_x((k + 1) % 4) - obs_x(k)) & 1023), 64'd256);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
